// File: rtl/wide_add_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_sequencer_if
// Brief    : Operand/result handshake bundle for wide_add_sequencer.
// Revision : 1.0
// ============================================================================
interface wide_add_sequencer_if #(
    parameter int N = 4,
    parameter int K = 4
);
    localparam int W = N * K;

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;

    modport master (
        output start, sub, a, b, c_in,
        input  busy, done, result, c_out
    );

    modport slave (
        input  start, sub, a, b, c_in,
        output busy, done, result, c_out
    );
endinterface
`default_nettype wire

// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_sequencer
// Brief    : W = N*K bit add/subtract built from one N-bit adder reused per slice.
// Revision : 1.0
// ============================================================================
module Nbit_Adder #(
    parameter int N = 4
) (
    input  wire logic [N-1:0] a,
    input  wire logic [N-1:0] b,
    input  wire logic         cin,
    output logic      [N-1:0] sum,
    output logic              cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

module wide_add_sequencer #(
    parameter int N = 4,
    parameter int K = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    wide_add_sequencer_if.slave   bus
);
    localparam int W     = N * K;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_result;
    logic               r_c_out;

    logic               w_accept;
    logic               w_last;
    logic [N-1:0]       w_a_slice;
    logic [N-1:0]       w_b_slice;
    logic [N-1:0]       w_sum;
    logic               w_cout;

    // start is only honoured when no operation is in flight
    assign w_accept  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last    = (r_idx == IDX_W'(K - 1));
    assign w_a_slice = r_a[r_idx*N +: N];
    assign w_b_slice = r_b[r_idx*N +: N];

    Nbit_Adder #(
        .N    (N)
    ) u_slice_adder (
        .a    (w_a_slice),
        .b    (w_b_slice),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  w_state_next = bus.start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1, so the inverted operand and forced carry are latched up front
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_c_out  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? 1'b1 : bus.c_in;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_result[r_idx*N +: N] <= w_sum;
            r_carry                <= w_cout;
            if (w_last) begin
                r_c_out <= w_cout;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign bus.busy   = (r_state == S_RUN);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;
    assign bus.c_out  = r_c_out;
endmodule
`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wide_add_sequencer
// Brief    : Self-checking bench: vector table, random ops vs. arithmetic model, corner sequences.
// Revision : 1.0
// ============================================================================
module tb_wide_add_sequencer;
    localparam int N = 4;
    localparam int K = 4;
    localparam int W = N * K;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   cyc;

    wide_add_sequencer_if #(.N(N), .K(K)) bus ();

    wide_add_sequencer #(
        .N     (N),
        .K     (K)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic         cout;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic; for subtract, carry-out means a >= b
    function automatic logic [W:0] model(input logic sub, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic cin);
        logic [W:0] s;
        if (sub) begin
            s[W-1:0] = a - b;
            s[W]     = (a >= b);
        end else begin
            s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        end
        return s;
    endfunction

    task automatic scramble();
        bus.a    = W'($urandom);
        bus.b    = W'($urandom);
        bus.sub  = 1'($urandom);
        bus.c_in = 1'($urandom);
    endtask

    // Called just after a rising edge; issues one op and checks timing and result
    task automatic run_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] exp_res, input logic exp_cout);
        int lat;
        int nb;
        bus.start = 1'b1;
        bus.sub   = sub;
        bus.a     = a;
        bus.b     = b;
        bus.c_in  = cin;
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble();
        chk("accept_busy", 32'(bus.busy), 32'd1);
        nb  = bus.busy ? 1 : 0;
        lat = 0;
        while (!bus.done && lat < K + 4) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy) nb++;
            bus.c_in = ~bus.c_in;
            chk("busy_done_overlap", 32'(bus.busy & bus.done), 32'd0);
        end
        chk("latency", 32'(lat), 32'(K));
        chk("busy_cycles", 32'(nb), 32'(K));
        chk("result", 32'(bus.result), 32'(exp_res));
        chk("c_out", 32'(bus.c_out), 32'(exp_cout));
        @(posedge clk); #1;
        chk("done_single", 32'(bus.done), 32'd0);
        chk("result_held", 32'(bus.result), 32'(exp_res));
    endtask

    initial begin
        logic [W:0] m;
        logic [W-1:0] ra, rb;
        logic rs, rc;
        int t1, t2, nd;
        logic b2b_busy;

        n_tests = 0; n_fail = 0; cyc = 0;
        vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b1, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b1};
        vecs[4] = '{1'b1, 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_c_out", 32'(bus.c_out), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res, vecs[i].cout);

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = (i % 5 == 0) ? ra : W'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            m  = model(rs, ra, rb, rc);
            run_op(rs, ra, rb, rc, m[W-1:0], m[W]);
        end

        // start pulsed mid-RUN with different operands must be ignored
        bus.start = 1'b1; bus.sub = 1'b0; bus.a = 16'h0F0F; bus.b = 16'h0101; bus.c_in = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.sub = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h1111; bus.c_in = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        nd = 0;
        while (!bus.done && nd < K + 4) begin
            @(posedge clk); #1; nd++;
        end
        chk("ignore_done_seen", 32'(bus.done), 32'd1);
        chk("ignore_result", 32'(bus.result), 32'h1010);
        chk("ignore_c_out", 32'(bus.c_out), 32'd0);
        @(posedge clk); #1;

        // start held through DONE: second op launches straight from DONE
        bus.start = 1'b1; bus.sub = 1'b0; bus.a = 16'h8000; bus.b = 16'h8000; bus.c_in = 1'b1;
        @(posedge clk); #1;
        bus.sub = 1'b1; bus.a = 16'h0005; bus.b = 16'h0003; bus.c_in = 1'b0;
        nd = 0; t1 = 0; t2 = 0; b2b_busy = 1'b0;
        for (int i = 0; i < 20 && nd < 2; i++) begin
            @(posedge clk); #1;
            if (nd == 1 && !bus.done) begin
                bus.start = 1'b0;
                if (t2 == 0) b2b_busy = bus.busy;
                t2 = -1;
            end
            if (bus.done) begin
                nd++;
                if (nd == 1) begin
                    t1 = cyc;
                    chk("b2b_res1", 32'(bus.result), 32'h0001);
                    chk("b2b_cout1", 32'(bus.c_out), 32'd1);
                end else begin
                    t2 = cyc;
                    chk("b2b_res2", 32'(bus.result), 32'h0002);
                    chk("b2b_cout2", 32'(bus.c_out), 32'd1);
                end
            end
        end
        bus.start = 1'b0;
        chk("b2b_done_count", 32'(nd), 32'd2);
        chk("b2b_restart_busy", 32'(b2b_busy), 32'd1);
        chk("b2b_gap", 32'(t2 - t1), 32'(K + 1));
        @(posedge clk); #1;

        // reset mid-RUN aborts the op with no done pulse
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        bus.start = 1'b1; bus.sub = 1'b0; bus.a = 16'h1111; bus.b = 16'h2222; bus.c_in = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_c_out", 32'(bus.c_out), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < K + 3; i++) begin
            @(posedge clk); #1;
            if (bus.done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        run_op(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/wide_add_sequencer.md
WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: width of the internal Nbit_Adder slice in bits.
REQ-002 SHALL have parameter K, default 4: number of slices; operand width W = N*K; K >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-006 SHALL have port sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-007 SHALL have port a  input  W  first operand; sampled with start.
REQ-008 SHALL have port b  input  W  second operand; sampled with start.
REQ-009 SHALL have port c_in  input  1  carry-in for add; sampled with start; ignored when sub=1.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress (RUN state).
REQ-011 SHALL have port done  output  1  single-cycle pulse: result and c_out valid.
REQ-012 SHALL have port result  output  W  sum/difference; held stable from done until next accepted start.
REQ-013 SHALL have port c_out  output  1  final carry-out; for subtract, 1 = no borrow.

Function
REQ-014 SHALL instantiate exactly one Nbit_Adder of width N and reuse it once per slice; no W-bit adder.
REQ-015 SHALL implement states IDLE, RUN, DONE; encoding free.
REQ-016 IDLE: start=1 -> latch a, b' (b' = sub ? ~b : b), carry register <= (sub ? 1 : c_in), slice index <= 0, go RUN.
REQ-017 IDLE: start=0 -> remain IDLE; all outputs hold.
REQ-018 RUN: each cycle SHALL add slice[idx] of a and b' with the carry register, write slice[idx] of result, store adder c_out in carry register, idx <= idx+1.
REQ-019 Slices SHALL be processed LSB first; slice idx occupies bits [idx*N +: N].
REQ-020 RUN: after slice K-1 is written, go DONE; c_out <= final carry.
REQ-021 DONE: done=1 for exactly one cycle; then IDLE, or RUN directly if start=1 in DONE (same latch actions as REQ-016).
REQ-022 Latency: start accepted at edge t -> done high during cycle after edge t+K; back-to-back throughput one operation per K+1 cycles.
REQ-023 busy SHALL be 1 exactly in RUN (K cycles per operation); done and busy never high together.
REQ-024 start while in RUN SHALL be ignored; operands already latched SHALL NOT change.
REQ-025 Changes on a, b, sub, c_in outside the accepting cycle SHALL NOT affect the operation.
REQ-026 result slices not yet written during RUN are unspecified; result is only guaranteed valid from done onward.
REQ-027 Arithmetic is modulo 2^W; carry out of slice K-1 appears only on c_out, never in result.
REQ-028 The slice index counter SHALL be ceil(log2(K)) bits wide minimum and SHALL NOT wrap inside an operation.

Reset
REQ-029 rst_n=0 SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, result=0, c_out=0, carry and index registers 0.
REQ-030 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL be generated for it.
REQ-031 After rst_n deasserts, the first start SHALL be accepted on the first rising edge with start=1.

Verification (N=4, K=4)
REQ-032 add a=0x1234, b=0x4321, c_in=0 -> after 4 busy cycles, done pulse, result=0x5555, c_out=0.
REQ-033 add a=0xFFFF, b=0x0001, c_in=0 -> result=0x0000, c_out=1 (carry ripples through all 4 slices); a=0xFFFF, b=0xFFFF, c_in=1 -> result=0xFFFF, c_out=1.
REQ-034 sub a=0x1000, b=0x0001 -> result=0x0FFF, c_out=1; sub a=0x0001, b=0x0002 -> result=0xFFFF, c_out=0; c_in toggled during both with no effect.
REQ-035 start pulsed with new operands during RUN -> ignored; result matches first operands; start held through DONE -> second op begins, two done pulses exactly 5 cycles apart.
REQ-036 rst_n pulsed low after 2 RUN cycles -> busy=0, result=0, c_out=0 immediately; no done; fresh start afterward completes correctly.
